// File: rtl/sad_job_sequencer.sv
// rtl/sad_job_sequencer.sv - SAD accelerator job sequencer: command decode, candidate issue, min-SAD tracking
module sad_job_sequencer #(
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int CLEAR_CYCLES   = 4
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic [31:0] cfg_data,
   input  logic        cfg_lz,
   output logic        cfg_vz,
   output logic [15:0] lambda_value,
   output logic        lambda_load,
   input  logic        lambda_loaded,
   output logic        lcu_load,
   input  logic        lcu_loaded,
   output logic        sad_start,
   input  logic [1:0]  sad_ready,
   input  logic [63:0] sad_value,
   output logic [31:0] sad_result_low,
   output logic [31:0] sad_result_high,
   output logic [15:0] best_index,
   output logic [1:0]  result_ready,
   output logic        clear_fifo,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_LAMBDA, S_LCU, S_ISSUE, S_WAIT_SAD, S_CLEAR
   } state_t;

   localparam int MAX_CYC = (TIMEOUT_CYCLES > CLEAR_CYCLES) ? TIMEOUT_CYCLES : CLEAR_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          pop_hold;
   logic [15:0]   lambda_d, count, count_d, idx, idx_d, best_d;
   logic [63:0]   min_sad, min_d, result, result_d, cand;
   logic [1:0]    rr_d;
   logic [1:0]    op;
   logic [15:0]   arg;
   logic          timed_out;
   logic          unused_cfg_bits;

   assign op              = cfg_data[31:30];
   assign arg             = cfg_data[15:0];
   assign unused_cfg_bits = ^cfg_data[29:16];

   // pop_hold enforces a gap of at least one cycle between consecutive pops
   assign cfg_vz    = (state == S_IDLE) && cfg_lz && !pop_hold;
   assign timed_out = (cnt == TO_LAST);

   assign lambda_load     = (state == S_LAMBDA);
   assign lcu_load        = (state == S_LCU);
   assign sad_start       = (state == S_ISSUE);
   assign clear_fifo      = (state == S_CLEAR);
   assign busy            = (state != S_IDLE);
   assign sad_result_low  = result[31:0];
   assign sad_result_high = result[63:32];

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         pop_hold     <= 1'b0;
         lambda_value <= '0;
         count        <= '0;
         idx          <= '0;
         best_index   <= '0;
         min_sad      <= '1;
         result       <= '0;
         result_ready <= '0;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         pop_hold     <= cfg_vz;
         lambda_value <= lambda_d;
         count        <= count_d;
         idx          <= idx_d;
         best_index   <= best_d;
         min_sad      <= min_d;
         result       <= result_d;
         result_ready <= rr_d;
      end
   end

   always_comb begin
      state_d  = state;
      lambda_d = lambda_value;
      count_d  = count;
      idx_d    = idx;
      best_d   = best_index;
      min_d    = min_sad;
      result_d = result;
      rr_d     = result_ready;
      // strict compare so ties keep the earlier candidate
      cand     = (sad_value < min_sad) ? sad_value : min_sad;

      case (state)
         S_IDLE: begin
            if (cfg_vz) begin
               case (op)
                  2'b00: begin
                     lambda_d = arg;
                     state_d  = S_LAMBDA;
                  end
                  2'b01: begin
                     count_d = arg;
                     idx_d   = '0;
                     min_d   = '1;
                     rr_d    = 2'b00;
                     state_d = S_LCU;
                  end
                  2'b10:   state_d = S_CLEAR;
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_LAMBDA: begin
            if (lambda_loaded) begin
               state_d = S_IDLE;
            end else if (timed_out) begin
               rr_d    = 2'b11;
               state_d = S_CLEAR;
            end
         end
         S_LCU: begin
            if (lcu_loaded) begin
               if (count == 16'd0) begin
                  rr_d    = 2'b01;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_ISSUE;
               end
            end else if (timed_out) begin
               rr_d    = 2'b11;
               state_d = S_CLEAR;
            end
         end
         S_ISSUE: state_d = S_WAIT_SAD;
         S_WAIT_SAD: begin
            if (sad_ready[1]) begin
               rr_d    = 2'b10;
               state_d = S_CLEAR;
            end else if (sad_ready[0]) begin
               if (sad_value < min_sad) begin
                  min_d  = sad_value;
                  best_d = idx;
               end
               if (idx == count - 16'd1) begin
                  result_d = cand;
                  rr_d     = 2'b01;
                  state_d  = S_IDLE;
               end else begin
                  idx_d   = idx + 16'd1;
                  state_d = S_ISSUE;
               end
            end else if (timed_out) begin
               rr_d    = 2'b11;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (cnt == CLR_LAST) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // one counter serves the wait-state timeout and the clear pulse length
      if (state_d != state)     cnt_d = '0;
      else if (state == S_IDLE) cnt_d = cnt;
      else                      cnt_d = cnt + CW'(1);
   end

endmodule

// File: tb/tb_sad_job_sequencer.sv
// tb/tb_sad_job_sequencer.sv - randomized self-checking bench for sad_job_sequencer
module tb_sad_job_sequencer;
   localparam int TO = 16;
   localparam int CC = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cfg_data;
   logic        cfg_lz, cfg_vz;
   logic [15:0] lambda_value;
   logic        lambda_load, lambda_loaded;
   logic        lcu_load, lcu_loaded;
   logic        sad_start;
   logic [1:0]  sad_ready;
   logic [63:0] sad_value;
   logic [31:0] sad_result_low, sad_result_high;
   logic [15:0] best_index;
   logic [1:0]  result_ready;
   logic        clear_fifo, busy;

   sad_job_sequencer #(.TIMEOUT_CYCLES(TO), .CLEAR_CYCLES(CC)) dut (
      .clk_clk(clk), .reset_reset(rst),
      .cfg_data(cfg_data), .cfg_lz(cfg_lz), .cfg_vz(cfg_vz),
      .lambda_value(lambda_value), .lambda_load(lambda_load), .lambda_loaded(lambda_loaded),
      .lcu_load(lcu_load), .lcu_loaded(lcu_loaded),
      .sad_start(sad_start), .sad_ready(sad_ready), .sad_value(sad_value),
      .sad_result_low(sad_result_low), .sad_result_high(sad_result_high),
      .best_index(best_index), .result_ready(result_ready),
      .clear_fifo(clear_fifo), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int n_vz = 0, n_lam = 0, n_lcu = 0, n_start = 0, n_clr = 0;

   always @(posedge clk) if (cfg_vz) n_vz++;
   always @(negedge clk) begin
      if (lambda_load) n_lam++;
      if (lcu_load)    n_lcu++;
      if (sad_start)   n_start++;
      if (clear_fifo)  n_clr++;
   end

   // expected published state
   logic [63:0] exp_res;
   logic [15:0] exp_idx;
   logic [15:0] exp_lambda;
   logic [63:0] sads[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [15:0] arg);
      @(negedge clk);
      cfg_data = {op, 14'h0, arg};
      cfg_lz   = 1'b1;
      #1;
      chk("cfg_vz_pop", 64'(cfg_vz), 64'd1);
      @(negedge clk);
      cfg_lz   = 1'b0;
      cfg_data = $urandom;
   endtask

   task automatic ack_load(input bit is_lcu, input int n);
      int c = 0;
      bit done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         if (is_lcu ? lcu_load : lambda_load) c++;
         if (c == n) begin
            if (is_lcu) lcu_loaded = 1'b1; else lambda_loaded = 1'b1;
            @(negedge clk);
            lcu_loaded = 1'b0;
            lambda_loaded = 1'b0;
            done = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      chk("load_ack_done", 64'(done), 64'd1);
   endtask

   task automatic wait_start();
      bit seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (sad_start) seen = 1'b1; else @(negedge clk);
      end
      chk("sad_start_seen", 64'(seen), 64'd1);
   endtask

   task automatic wait_idle();
      bit idle = 1'b0;
      for (int k = 0; k < 40 && !idle; k++) begin
         @(negedge clk);
         if (!busy) idle = 1'b1;
      end
      chk("return_idle", 64'(idle), 64'd1);
   endtask

   // reference: first candidate holding the strict minimum, starting from all-ones
   task automatic run_job();
      logic [63:0] m = '1;
      int s0;
      for (int i = 0; i < sads.size(); i++)
         if (sads[i] < m) begin
            m = sads[i];
            exp_idx = 16'(i);
         end
      exp_res = m;
      s0 = n_start;
      send_cmd(2'b01, 16'(sads.size()));
      chk("start_rr_clear", 64'(result_ready), 64'd0);
      ack_load(1'b1, int'($urandom_range(1, 4)));
      for (int i = 0; i < sads.size(); i++) begin
         wait_start();
         @(negedge clk);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         sad_ready = 2'b01;
         sad_value = sads[i];
         @(negedge clk);
         sad_ready = 2'b00;
         sad_value = {$urandom, $urandom};
      end
      chk("job_low", 64'(sad_result_low), 64'(exp_res[31:0]));
      chk("job_high", 64'(sad_result_high), 64'(exp_res[63:32]));
      chk("job_best", 64'(best_index), 64'(exp_idx));
      chk("job_rr", 64'(result_ready), 64'd1);
      chk("job_busy", 64'(busy), 64'd0);
      chk("job_starts", 64'(n_start - s0), 64'(sads.size()));
   endtask

   initial begin
      int s0, c0, l0, v0;
      rst = 1'b1;
      cfg_data = '0; cfg_lz = 1'b0;
      lambda_loaded = 1'b0; lcu_loaded = 1'b0;
      sad_ready = 2'b00; sad_value = '0;
      exp_res = '0; exp_idx = '0; exp_lambda = '0;
      repeat (2) @(negedge clk);
      chk("rst_outputs", {sad_result_high, sad_result_low}, 64'd0);
      chk("rst_ctrl", 64'({lambda_value, best_index, result_ready, lambda_load, lcu_load,
                           sad_start, clear_fifo, busy, cfg_vz}), 64'd0);
      rst = 1'b0;

      // lambda load with a 3-cycle ack, and a pop attempt while busy
      l0 = n_lam; v0 = n_vz;
      send_cmd(2'b00, 16'h0123);
      exp_lambda = 16'h0123;
      cfg_lz = 1'b1; cfg_data = 32'h4000_0005;
      #1;
      chk("no_pop_busy", 64'(cfg_vz), 64'd0);
      cfg_lz = 1'b0;
      ack_load(1'b0, 3);
      chk("lambda_value", 64'(lambda_value), 64'(exp_lambda));
      chk("lambda_cycles", 64'(n_lam - l0), 64'd3);
      chk("lambda_pops", 64'(n_vz - v0), 64'd1);
      chk("lambda_load_low", 64'(lambda_load), 64'd0);

      // reserved op held for two cycles: one pop, no state change
      v0 = n_vz;
      @(negedge clk);
      cfg_data = 32'hC000_7777; cfg_lz = 1'b1;
      @(negedge clk);
      #1;
      chk("pop_gap", 64'(cfg_vz), 64'd0);
      @(negedge clk);
      cfg_lz = 1'b0;
      #1;
      chk("rsvd_pops", 64'(n_vz - v0), 64'd1);
      chk("rsvd_busy", 64'(busy), 64'd0);

      sads = '{64'd500, 64'd200, 64'd200};
      run_job();

      for (int j = 0; j < 4; j++) begin
         sads.delete();
         for (int i = 0; i < int'($urandom_range(1, 6)); i++)
            sads.push_back(($urandom_range(0, 2) == 0) ? 64'(100 * $urandom_range(1, 3))
                                                      : {$urandom, $urandom});
         run_job();
      end

      // empty job: handshake only, results untouched
      s0 = n_start;
      send_cmd(2'b01, 16'd0);
      ack_load(1'b1, 2);
      chk("empty_rr", 64'(result_ready), 64'd1);
      chk("empty_res", {sad_result_high, sad_result_low}, exp_res);
      chk("empty_best", 64'(best_index), 64'(exp_idx));
      chk("empty_starts", 64'(n_start - s0), 64'd0);

      // accelerator error coinciding with a valid, smaller SAD
      s0 = n_start; c0 = n_clr;
      send_cmd(2'b01, 16'd2);
      ack_load(1'b1, 1);
      wait_start();
      @(negedge clk);
      sad_ready = 2'b11; sad_value = 64'd1;
      @(negedge clk);
      sad_ready = 2'b00;
      wait_idle();
      chk("err_rr", 64'(result_ready), 64'd2);
      chk("err_clear_cycles", 64'(n_clr - c0), 64'(CC));
      chk("err_res", {sad_result_high, sad_result_low}, exp_res);
      chk("err_best", 64'(best_index), 64'(exp_idx));
      chk("err_starts", 64'(n_start - s0), 64'd1);

      // lcu never acknowledged
      l0 = n_lcu; c0 = n_clr;
      send_cmd(2'b01, 16'd1);
      wait_idle();
      chk("to_lcu_cycles", 64'(n_lcu - l0), 64'(TO));
      chk("to_rr", 64'(result_ready), 64'd3);
      chk("to_clear_cycles", 64'(n_clr - c0), 64'(CC));
      chk("to_res", {sad_result_high, sad_result_low}, exp_res);

      // reset in WAIT_SAD, then abort
      send_cmd(2'b01, 16'd2);
      ack_load(1'b1, 1);
      wait_start();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_res", {sad_result_high, sad_result_low}, 64'd0);
      chk("mid_rst_ctrl", 64'({lambda_value, best_index, result_ready, lambda_load, lcu_load,
                               sad_start, clear_fifo, busy}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      s0 = n_start; c0 = n_clr;
      send_cmd(2'b10, 16'h0);
      wait_idle();
      chk("abort_clear_cycles", 64'(n_clr - c0), 64'(CC));
      chk("abort_rr", 64'(result_ready), 64'd0);
      chk("abort_res", {sad_result_high, sad_result_low}, 64'd0);
      chk("abort_starts", 64'(n_start - s0), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
